// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: state encodings, opcodes, error codes.
// The CHK state exists only when UART_CMD_PARSER_CHECKSUM_EN is defined.
package uart_cmd_parser_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] OP_WRITE      = 8'h01;
    localparam logic [7:0] OP_READ       = 8'h02;

    typedef enum logic [1:0] {
        ERR_CHECKSUM = 2'b00,
        ERR_BAD_OP   = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_OVERRUN  = 2'b11
    } err_code_t;

`ifdef UART_CMD_PARSER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_ADDR = 3'd2,
        ST_DH   = 3'd3,
        ST_DL   = 3'd4,
        ST_CHK  = 3'd5,
        ST_HOLD = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_ADDR = 3'd2,
        ST_DH   = 3'd3,
        ST_DL   = 3'd4,
        ST_HOLD = 3'd6
    } state_t;
`endif

    function automatic logic op_is_valid(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_gap_timer.sv
// Inter-byte gap timer: counts while enabled, pulses o_expire on the last allowed cycle.
// A clear on the same cycle suppresses the expiry so an arriving byte always wins.
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles UART bytes into command frames and hands decoded commands over valid/ready.
// Define UART_CMD_PARSER_CHECKSUM_EN for the 6-byte frame with trailing XOR checksum.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    input  logic        cmd_ready_in,
    output logic        cmd_valid_out,
    output logic [7:0]  cmd_op_out,
    output logic [7:0]  cmd_addr_out,
    output logic [15:0] cmd_data_out,
    output logic        err_out,
    output logic [1:0]  err_code_out,
    output logic        busy_out
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_op_stg;
    logic [7:0]  r_addr_stg;
    logic [7:0]  r_dh_stg;
    logic [7:0]  r_op;
    logic [7:0]  r_addr;
    logic [15:0] r_data;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic        w_load;
    logic        w_err;
    err_code_t   w_err_code;
    logic [15:0] w_data_ld;
    logic        w_in_frame;
    logic        w_tmr_clear;
    logic        w_expire;

`ifdef UART_CMD_PARSER_CHECKSUM_EN
    logic [7:0]  r_dl_stg;
    logic        w_chk_ok;
    assign w_chk_ok  = rx_data_in == (r_op_stg ^ r_addr_stg ^ r_dh_stg ^ r_dl_stg);
    assign w_data_ld = {r_dh_stg, r_dl_stg};
`else
    assign w_data_ld = {r_dh_stg, rx_data_in};
`endif

    assign w_in_frame  = (r_state != ST_IDLE) && (r_state != ST_HOLD);
    assign w_tmr_clear = rx_valid_in || (r_state == ST_IDLE);

    uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_clear  (w_tmr_clear),
        .i_enable (w_in_frame),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ERR_CHECKSUM;
        if (w_expire) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
            w_err_code  = ERR_TIMEOUT;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_valid_in && (rx_data_in == SYNC_BYTE)) begin
                        w_state_nxt = ST_OP;
                    end
                end
                ST_OP:   if (rx_valid_in) w_state_nxt = ST_ADDR;
                ST_ADDR: if (rx_valid_in) w_state_nxt = ST_DH;
                ST_DH:   if (rx_valid_in) w_state_nxt = ST_DL;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                ST_DL:   if (rx_valid_in) w_state_nxt = ST_CHK;
                ST_CHK: begin
                    if (rx_valid_in) begin
                        // Checksum is judged before the opcode
                        if (!w_chk_ok) begin
                            w_state_nxt = ST_IDLE;
                            w_err       = 1'b1;
                            w_err_code  = ERR_CHECKSUM;
                        end else if (!op_is_valid(r_op_stg)) begin
                            w_state_nxt = ST_IDLE;
                            w_err       = 1'b1;
                            w_err_code  = ERR_BAD_OP;
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_load      = 1'b1;
                        end
                    end
                end
`else
                ST_DL: begin
                    if (rx_valid_in) begin
                        if (!op_is_valid(r_op_stg)) begin
                            w_state_nxt = ST_IDLE;
                            w_err       = 1'b1;
                            w_err_code  = ERR_BAD_OP;
                        end else begin
                            w_state_nxt = ST_HOLD;
                            w_load      = 1'b1;
                        end
                    end
                end
`endif
                ST_HOLD: begin
                    if (rx_valid_in) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_OVERRUN;
                    end
                    if (cmd_ready_in) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_op_stg   <= '0;
            r_addr_stg <= '0;
            r_dh_stg   <= '0;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            r_dl_stg   <= '0;
`endif
        end else if (rx_valid_in) begin
            case (r_state)
                ST_OP:   r_op_stg   <= rx_data_in;
                ST_ADDR: r_addr_stg <= rx_data_in;
                ST_DH:   r_dh_stg   <= rx_data_in;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                ST_DL:   r_dl_stg   <= rx_data_in;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_err <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
            if (w_load) begin
                r_op   <= r_op_stg;
                r_addr <= r_addr_stg;
                r_data <= w_data_ld;
            end
        end
    end

    assign cmd_valid_out = (r_state == ST_HOLD);
    assign cmd_op_out    = r_op;
    assign cmd_addr_out  = r_addr;
    assign cmd_data_out  = r_data;
    assign err_out       = r_err;
    assign err_code_out  = r_err_code;
    assign busy_out      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame table, hand sequences, random frames.
// Follows UART_CMD_PARSER_CHECKSUM_EN to choose 5- or 6-byte frames.
module tb_uart_cmd_parser;

    localparam int TMO = 64;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
    localparam int LEN    = 6;
`else
    localparam bit CHK_EN = 1'b0;
    localparam int LEN    = 5;
`endif

    logic        clk_in = 1'b0;
    logic        rst;
    logic        rx_valid_in;
    logic [7:0]  rx_data_in;
    logic        cmd_ready_in;
    logic        cmd_valid_out;
    logic [7:0]  cmd_op_out;
    logic [7:0]  cmd_addr_out;
    logic [15:0] cmd_data_out;
    logic        err_out;
    logic [1:0]  err_code_out;
    logic        busy_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .rx_valid_in   (rx_valid_in),
        .rx_data_in    (rx_data_in),
        .cmd_ready_in  (cmd_ready_in),
        .cmd_valid_out (cmd_valid_out),
        .cmd_op_out    (cmd_op_out),
        .cmd_addr_out  (cmd_addr_out),
        .cmd_data_out  (cmd_data_out),
        .err_out       (err_out),
        .err_code_out  (err_code_out),
        .busy_out      (busy_out)
    );

    // Observed events: error strobes and accepted commands
    int          mon_err_cnt = 0;
    logic [1:0]  mon_last_code = 2'b00;
    logic [31:0] mon_cmds[$];

    always @(negedge clk_in) begin
        if (err_out) begin
            mon_err_cnt++;
            mon_last_code = err_code_out;
        end
        if (cmd_valid_out && cmd_ready_in)
            mon_cmds.push_back({cmd_op_out, cmd_addr_out, cmd_data_out});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk_in);
        #1;
    endtask

    // Entered and left at posedge+1; gap = idle cycles before the strobe
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) align();
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        align();
        rx_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int k = 0; k < LEN; k++) send_byte(f[47-8*k -: 8], 0);
    endtask

    task automatic handshake();
        cmd_ready_in = 1'b1;
        align();
        cmd_ready_in = 1'b0;
    endtask

    typedef struct packed {
        logic [47:0] b;
        logic        ok;
        logic [1:0]  code;
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[6];

    localparam logic [47:0] FRAME1 = 48'hA5_01_48_C3_83_09;

    // Reference outcome of a completed frame: -1 ok, else error code
    function automatic int frame_outcome(input logic [7:0] op, input logic [7:0] ad,
                                         input logic [7:0] dh, input logic [7:0] dl,
                                         input logic [7:0] ck);
        if (CHK_EN && (ck != (op ^ ad ^ dh ^ dl))) return 0;
        if (op != 8'h01 && op != 8'h02) return 1;
        return -1;
    endfunction

    initial begin
        rst          = 1'b1;
        rx_valid_in  = 1'b0;
        rx_data_in   = 8'h00;
        cmd_ready_in = 1'b0;

        tbl[0] = '{FRAME1,                 1'b1, 2'b00, 8'h01, 8'h48, 16'hC383};
        tbl[2] = '{48'hA5_02_48_00_00_4A,  1'b1, 2'b00, 8'h02, 8'h48, 16'h0000};
        tbl[3] = '{48'hA5_07_48_C3_83_0F,  1'b0, 2'b01, 8'h00, 8'h00, 16'h0000};
        tbl[4] = '{48'hA5_01_A5_A5_A5_A4,  1'b1, 2'b00, 8'h01, 8'hA5, 16'hA5A5};
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        tbl[1] = '{48'hA5_01_48_C3_83_0A,  1'b0, 2'b00, 8'h00, 8'h00, 16'h0000};
        tbl[5] = '{48'hA5_03_00_00_00_00,  1'b0, 2'b00, 8'h00, 8'h00, 16'h0000};
`else
        tbl[1] = '{48'hA5_01_48_C3_83_0A,  1'b1, 2'b00, 8'h01, 8'h48, 16'hC383};
        tbl[5] = '{48'hA5_03_00_00_00_00,  1'b0, 2'b01, 8'h00, 8'h00, 16'h0000};
`endif

        // Reset state
        @(negedge clk_in);
        check("rst valid", cmd_valid_out, 0);
        check("rst fields", {cmd_op_out, cmd_addr_out, cmd_data_out}, 0);
        check("rst err", {err_out, err_code_out}, 0);
        check("rst busy", busy_out, 0);
        align();
        rst = 1'b0;
        align();

        // Frame table; the check right after the last byte also fixes latency
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].b);
            @(negedge clk_in);
            check($sformatf("tbl%0d valid", i), cmd_valid_out, tbl[i].ok);
            check($sformatf("tbl%0d err", i), err_out, !tbl[i].ok);
            if (tbl[i].ok) begin
                check($sformatf("tbl%0d cmd", i),
                      {cmd_op_out, cmd_addr_out, cmd_data_out},
                      {tbl[i].op, tbl[i].addr, tbl[i].data});
            end else begin
                check($sformatf("tbl%0d code", i), err_code_out, tbl[i].code);
            end
            align();
            handshake();
            @(negedge clk_in);
            check($sformatf("tbl%0d idle", i), {cmd_valid_out, busy_out}, 0);
            align();
        end

        // Held command with ready low for 5 cycles
        send_frame(FRAME1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("hold valid", cmd_valid_out, 1);
        end
        check("hold cmd", {cmd_op_out, cmd_addr_out, cmd_data_out}, 32'h0148C383);
        align();
        handshake();
        @(negedge clk_in);
        check("hold drop", {cmd_valid_out, busy_out}, 0);
        check("fields kept", {cmd_op_out, cmd_addr_out, cmd_data_out}, 32'h0148C383);
        align();

        // Leading junk in IDLE is discarded
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h12, 0);
        @(negedge clk_in);
        check("junk busy", {busy_out, err_out}, 0);
        align();
        send_frame(tbl[2].b);
        @(negedge clk_in);
        check("junk then cmd", {cmd_valid_out, cmd_op_out, cmd_addr_out, cmd_data_out},
              {1'b1, 32'h02480000});
        align();
        handshake();

        // Gap timeout: 64 idle cycles inside a frame
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h48, 0);
        repeat (TMO - 1) @(posedge clk_in);
        @(negedge clk_in);
        check("tmo not yet", {busy_out, err_out}, 2'b10);
        @(negedge clk_in);
        check("tmo strobe", {err_out, err_code_out, busy_out}, {1'b1, 2'b10, 1'b0});
        @(negedge clk_in);
        check("tmo one cycle", {err_out, err_code_out}, {1'b0, 2'b10});
        align();
        send_frame(FRAME1);
        @(negedge clk_in);
        check("after tmo", {cmd_valid_out, cmd_op_out}, {1'b1, 8'h01});
        align();
        handshake();

        // Byte on the last allowed cycle is accepted
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h48, 0);
        send_byte(8'hC3, TMO - 1);
        for (int k = 4; k < LEN; k++) send_byte(FRAME1[47-8*k -: 8], 0);
        @(negedge clk_in);
        check("gap edge", {cmd_valid_out, err_out, cmd_data_out}, {2'b10, 16'hC383});
        align();

        // Overrun while holding, then together with the handshake
        send_byte(8'h55, 0);
        @(negedge clk_in);
        check("ovr err", {err_out, err_code_out, cmd_valid_out}, {1'b1, 2'b11, 1'b1});
        check("ovr fields", {cmd_op_out, cmd_addr_out, cmd_data_out}, 32'h0148C383);
        align();
        rx_valid_in  = 1'b1;
        rx_data_in   = 8'h55;
        cmd_ready_in = 1'b1;
        align();
        rx_valid_in  = 1'b0;
        cmd_ready_in = 1'b0;
        @(negedge clk_in);
        check("ovr+hs", {err_out, err_code_out, cmd_valid_out, busy_out}, {1'b1, 2'b11, 2'b00});
        align();

        // Reset mid-frame
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        @(negedge clk_in);
        check("mid rst outs", {cmd_valid_out, cmd_op_out, cmd_addr_out, cmd_data_out,
                               err_out, err_code_out, busy_out}, 0);
        align();
        rst = 1'b0;
        align();
        send_frame(FRAME1);
        @(negedge clk_in);
        check("post rst cmd", {cmd_valid_out, cmd_op_out, cmd_addr_out, cmd_data_out},
              {1'b1, 32'h0148C383});
        align();
        handshake();
        align();

        // Random frames against the reference outcome
        begin
            int          exp_err;
            logic [31:0] exp_q[$];
            exp_err = mon_err_cnt;
            mon_cmds.delete();
            for (int f = 0; f < 60; f++) begin
                logic [7:0]  op, ad, dh, dl, ck, g;
                logic [47:0] fb;
                int          sent, res, mode, exp_code;
                bit          had_err;
                had_err  = 1'b0;
                exp_code = 0;
                op = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                     (($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02);
                ad = 8'($urandom);
                dh = 8'($urandom);
                dl = 8'($urandom);
                ck = op ^ ad ^ dh ^ dl;
                if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
                fb = {8'hA5, op, ad, dh, dl, ck};
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                    g = 8'($urandom);
                    if (g == 8'hA5) g = 8'h00;
                    send_byte(g, $urandom_range(0, 3));
                end
                sent = ($urandom_range(0, 9) == 0) ? $urandom_range(1, LEN - 1) : LEN;
                for (int k = 0; k < sent; k++)
                    send_byte(fb[47-8*k -: 8], $urandom_range(0, 5));
                if (sent < LEN) begin
                    repeat (TMO + 2) align();
                    exp_err++;
                    had_err  = 1'b1;
                    exp_code = 2;
                end else begin
                    res = frame_outcome(op, ad, dh, dl, ck);
                    if (res >= 0) begin
                        exp_err++;
                        had_err  = 1'b1;
                        exp_code = res;
                    end else begin
                        exp_q.push_back({op, ad, dh, dl});
                        repeat ($urandom_range(0, 3)) align();
                        mode = $urandom_range(0, 2);
                        if (mode == 1) begin
                            send_byte(8'($urandom), 0);
                            handshake();
                        end else if (mode == 2) begin
                            rx_valid_in  = 1'b1;
                            rx_data_in   = 8'($urandom);
                            cmd_ready_in = 1'b1;
                            align();
                            rx_valid_in  = 1'b0;
                            cmd_ready_in = 1'b0;
                        end else begin
                            handshake();
                        end
                        if (mode != 0) begin
                            exp_err++;
                            had_err  = 1'b1;
                            exp_code = 3;
                        end
                    end
                    align();
                end
                @(negedge clk_in);
                check($sformatf("rnd%0d errs", f), mon_err_cnt, exp_err);
                if (had_err) check($sformatf("rnd%0d code", f), mon_last_code, exp_code);
                check($sformatf("rnd%0d ncmd", f), mon_cmds.size(), exp_q.size());
                while (mon_cmds.size() > 0 && exp_q.size() > 0)
                    check($sformatf("rnd%0d cmd", f), mon_cmds.pop_front(), exp_q.pop_front());
                check($sformatf("rnd%0d idle", f), busy_out, 0);
                align();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
